// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants, scan-state type and anode helper for the
//                8-digit multiplexed seven-segment scan controller.
//  Contents    : DIG_NUM   - number of digits (fixed at 8)
//                NUM_W     - width of the digit index
//                ANODE_OFF - active-low anode pattern with every digit dark
//                scan_state_t - IDLE / GUARD / SHOW
//                anode_pattern() - active-low anode word for one digit
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int DIG_NUM = 8;
    localparam int NUM_W   = 3;

    localparam logic [DIG_NUM-1:0] ANODE_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Anodes are active-low: the selected digit goes low only when its mask
    // bit is set, otherwise the slot stays dark but still takes its time.
    function automatic logic [DIG_NUM-1:0] anode_pattern(
        input logic [NUM_W-1:0]   idx,
        input logic [DIG_NUM-1:0] mask
    );
        return ~((DIG_NUM'(1) << idx) & mask);
    endfunction

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/clk_div_tick.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_tick
//  Description : Modulo-DIV counter with synchronous clear and count enable.
//                Counts 0..DIV-1 while enabled and wraps to 0.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                clr_i  - synchronous clear to 0 (dominates enable)
//                en_i   - count enable
//                cnt_o  - current count
//                tc_o   - terminal count: high while enabled at DIV-1
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_tick #(
    parameter int DIV   = 10,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tc_d;

    // Terminal count is combinational so the consumer can act on the very
    // edge that wraps the counter; a pending clear suppresses it.
    assign tc_d = en_i && !clr_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_d ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_d;

endmodule : clk_div_tick
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan
//  Description : Scan controller for an 8-digit multiplexed seven-segment
//                display. Each digit slot is DIV clocks long and opens with
//                GUARD_CYCLES of all-dark anodes to suppress ghosting.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                en         - scan enable; low blanks and freezes the index
//                digit_mask - per-digit lit enable (bit i = digit i)
//                num        - current digit index, mux select
//                an         - active-low anode enables
//                tick       - one-cycle pulse on each digit advance
//                frame_done - one-cycle pulse when num wraps 7 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DIG_NUM-1:0] digit_mask,
    output logic [NUM_W-1:0]   num,
    output logic [DIG_NUM-1:0] an,
    output logic               tick,
    output logic               frame_done
);

    localparam int DIV   = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    // Only meaningful when GUARD_CYCLES > 0; the GUARD state is never entered
    // otherwise.
    localparam logic [CNT_W-1:0] GUARD_LAST =
        CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'(DIG_NUM - 1);

    if ((DIV < 2) || (GUARD_CYCLES < 0) || (GUARD_CYCLES >= DIV)) begin : g_param_check
        $fatal(1, "seven_seg_scan: need DIV >= 2 and 0 <= GUARD_CYCLES < DIV");
    end

    scan_state_t        state_q;
    logic [NUM_W-1:0]   num_q;
    logic [NUM_W-1:0]   num_d;
    logic [DIG_NUM-1:0] an_q;
    logic               tick_q;
    logic               frame_done_q;

    logic [CNT_W-1:0]   div_cnt;
    logic               div_tc;
    logic               div_clr;
    logic               div_en;

    // Dropping en clears the divider on the same edge the FSM goes IDLE, so a
    // re-enable always begins a fresh slot at count 0. The divider holds in
    // IDLE, which makes the first active cycle after IDLE count 0.
    assign div_clr = !en;
    assign div_en  = en && (state_q != IDLE);

    clk_div_tick #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (div_clr),
        .en_i  (div_en),
        .cnt_o (div_cnt),
        .tc_o  (div_tc)
    );

    assign num_d = num_q + NUM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            an_q         <= ANODE_OFF;
            tick_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= 1'b0;
            frame_done_q <= 1'b0;
            if (!en) begin
                // Enable has priority over a coinciding advance.
                state_q <= IDLE;
                an_q    <= ANODE_OFF;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (GUARD_CYCLES == 0) begin
                            state_q <= SHOW;
                            an_q    <= anode_pattern(num_q, digit_mask);
                        end else begin
                            state_q <= GUARD;
                            an_q    <= ANODE_OFF;
                        end
                    end
                    GUARD: begin
                        // Load the lit pattern on the last guard count so it
                        // appears exactly when the count reaches GUARD_CYCLES.
                        if (div_cnt == GUARD_LAST) begin
                            state_q <= SHOW;
                            an_q    <= anode_pattern(num_q, digit_mask);
                        end else begin
                            an_q    <= ANODE_OFF;
                        end
                    end
                    SHOW: begin
                        if (div_tc) begin
                            num_q        <= num_d;
                            tick_q       <= 1'b1;
                            frame_done_q <= (num_q == NUM_LAST);
                            if (GUARD_CYCLES == 0) begin
                                state_q <= SHOW;
                                an_q    <= anode_pattern(num_d, digit_mask);
                            end else begin
                                state_q <= GUARD;
                                an_q    <= ANODE_OFF;
                            end
                        end else begin
                            an_q <= anode_pattern(num_q, digit_mask);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        an_q    <= ANODE_OFF;
                    end
                endcase
            end
        end
    end

    assign num        = num_q;
    assign an         = an_q;
    assign tick       = tick_q;
    assign frame_done = frame_done_q;

endmodule : seven_seg_scan
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan
//  Description : Directed self-checking bench for seven_seg_scan. Two
//                instances: DIV=10 with GUARD_CYCLES=2, and DIV=10 with
//                GUARD_CYCLES=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    logic       clk;
    logic       rst_n;
    logic       rst0_n;
    logic       en;
    logic       en0;
    logic [7:0] mask;

    logic [2:0] num,  num0;
    logic [7:0] an,   an0;
    logic       tick, tick0;
    logic       fd,   fd0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] pat [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    seven_seg_scan #(
        .CLK_FREQ_HZ  (100),
        .SCAN_HZ      (10),
        .GUARD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_mask (mask),
        .num        (num),
        .an         (an),
        .tick       (tick),
        .frame_done (fd)
    );

    seven_seg_scan #(
        .CLK_FREQ_HZ  (100),
        .SCAN_HZ      (10),
        .GUARD_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst0_n),
        .en         (en0),
        .digit_mask (mask),
        .num        (num0),
        .an         (an0),
        .tick       (tick0),
        .frame_done (fd0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed an=%h num=%0d tick=%b fd=%b, expected an=%h num=%0d tick=%b fd=%b",
                   tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic cm(input string tag, input logic [7:0] a, input logic [2:0] n,
                      input logic t, input logic f);
        chk(tag, {an, num, tick, fd}, {a, n, t, f});
    endtask

    task automatic c0(input string tag, input logic [7:0] a, input logic [2:0] n,
                      input logic t, input logic f);
        chk(tag, {an0, num0, tick0, fd0}, {a, n, t, f});
    endtask

    initial begin
        rst_n  = 1'b1;
        rst0_n = 1'b1;
        en     = 1'b0;
        en0    = 1'b0;
        mask   = 8'hFF;
        #2;
        rst_n  = 1'b0;
        rst0_n = 1'b0;

        // Reset state
        tk();
        cm("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
        c0("reset_g0", 8'hFF, 3'd0, 1'b0, 1'b0);

        // 1. Basic slot timing
        rst_n = 1'b1;
        en    = 1'b1;
        tk(); cm("t1_guard_c0", 8'hFF, 3'd0, 1'b0, 1'b0);
        tk(); cm("t1_guard_c1", 8'hFF, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t1_show_d0", 8'hFE, 3'd0, 1'b0, 1'b0);
        end
        tk(); cm("t1_advance", 8'hFF, 3'd1, 1'b1, 1'b0);
        tk(); cm("t1_guard_d1", 8'hFF, 3'd1, 1'b0, 1'b0);
        tk(); cm("t1_show_d1", 8'hFD, 3'd1, 1'b0, 1'b0);

        // 2. Frame wrap
        for (int i = 0; i < 7; i++) begin
            tk(); cm("t2_show_d1", 8'hFD, 3'd1, 1'b0, 1'b0);
        end
        for (int d = 2; d < 8; d++) begin
            tk(); cm("t2_advance", 8'hFF, 3'(d), 1'b1, 1'b0);
            tk(); cm("t2_guard", 8'hFF, 3'(d), 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) begin
                tk(); cm("t2_show", pat[d], 3'(d), 1'b0, 1'b0);
            end
        end
        tk(); cm("t2_wrap", 8'hFF, 3'd0, 1'b1, 1'b1);

        // 3. Masking
        mask = 8'hF0;
        tk(); cm("t3_guard_d0", 8'hFF, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t3_masked_d0", 8'hFF, 3'd0, 1'b0, 1'b0);
        end
        tk(); cm("t3_adv_d1", 8'hFF, 3'd1, 1'b1, 1'b0);
        tk(); cm("t3_guard_d1", 8'hFF, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t3_masked_d1", 8'hFF, 3'd1, 1'b0, 1'b0);
        end
        tk(); cm("t3_adv_d2", 8'hFF, 3'd2, 1'b1, 1'b0);
        tk(); cm("t3_guard_d2", 8'hFF, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tk(); cm("t3_masked_d2", 8'hFF, 3'd2, 1'b0, 1'b0);
        end
        mask = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tk(); cm("t3_unmask_d2", 8'hFB, 3'd2, 1'b0, 1'b0);
        end
        mask = 8'hF0;
        tk(); cm("t3_adv_d3", 8'hFF, 3'd3, 1'b1, 1'b0);
        tk(); cm("t3_guard_d3", 8'hFF, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t3_masked_d3", 8'hFF, 3'd3, 1'b0, 1'b0);
        end
        tk(); cm("t3_adv_d4", 8'hFF, 3'd4, 1'b1, 1'b0);
        tk(); cm("t3_guard_d4", 8'hFF, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t3_show_d4", 8'hEF, 3'd4, 1'b0, 1'b0);
        end

        // 4. Enable drop mid-show, then at the advance point
        mask = 8'hFF;
        tk(); cm("t4_adv_d5", 8'hFF, 3'd5, 1'b1, 1'b0);
        tk(); cm("t4_guard_d5", 8'hFF, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tk(); cm("t4_show_d5", 8'hDF, 3'd5, 1'b0, 1'b0);
        end
        en = 1'b0;
        tk(); cm("t4_en_drop", 8'hFF, 3'd5, 1'b0, 1'b0);
        tk(); cm("t4_idle", 8'hFF, 3'd5, 1'b0, 1'b0);
        en = 1'b1;
        tk(); cm("t4_reguard_c0", 8'hFF, 3'd5, 1'b0, 1'b0);
        tk(); cm("t4_reguard_c1", 8'hFF, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t4_reshow", 8'hDF, 3'd5, 1'b0, 1'b0);
        end
        en = 1'b0;
        tk(); cm("t4_en_priority", 8'hFF, 3'd5, 1'b0, 1'b0);
        en = 1'b1;
        tk(); cm("t4_reguard2_c0", 8'hFF, 3'd5, 1'b0, 1'b0);
        tk(); cm("t4_reguard2_c1", 8'hFF, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tk(); cm("t4_reshow2", 8'hDF, 3'd5, 1'b0, 1'b0);
        end
        tk(); cm("t4_adv_d6", 8'hFF, 3'd6, 1'b1, 1'b0);

        // 5. Asynchronous reset mid-slot
        tk(); cm("t5_guard_d6", 8'hFF, 3'd6, 1'b0, 1'b0);
        tk(); cm("t5_show_d6a", 8'hBF, 3'd6, 1'b0, 1'b0);
        tk(); cm("t5_show_d6b", 8'hBF, 3'd6, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cm("t5_async_reset", 8'hFF, 3'd0, 1'b0, 1'b0);
        tk(); cm("t5_reset_hold", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tk(); cm("t5_restart_c0", 8'hFF, 3'd0, 1'b0, 1'b0);
        tk(); cm("t5_restart_c1", 8'hFF, 3'd0, 1'b0, 1'b0);
        tk(); cm("t5_restart_show", 8'hFE, 3'd0, 1'b0, 1'b0);

        // 6. GUARD_CYCLES = 0 instance
        rst0_n = 1'b1;
        en0    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tk(); c0("t6_show_d0", 8'hFE, 3'd0, 1'b0, 1'b0);
        end
        tk(); c0("t6_advance", 8'hFD, 3'd1, 1'b1, 1'b0);
        tk(); c0("t6_show_d1", 8'hFD, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seven_seg_scan
`default_nettype wire
